mac_sequencer: RTL and testbench
================================

# mac_sequencer

- Upstream control and operand stage for `mac_datapath`.
- Buffers 4-bit operand pairs from a producer through a small valid/ready FIFO.
- On `start`, runs an FSM that presents `N_TERMS` pairs on `A`/`B` one at a time. For each pair it pulses the datapath strobes in order: `load_a`/`load_b`, then `load_m`, then `load_acc` plus `count_enable`.
- Finishes with `load_out` and a one-cycle completion pulse.

## Interface
- `DATA_W`, 4, operand width; must match datapath `A`/`B`.
- `N_TERMS`, 10, products accumulated per run; legal range 1–15.
- `FIFO_DEPTH`, 4, operand FIFO entries; power of two.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a run; sampled only in IDLE.
- `in_valid` in 1: producer has an operand pair.
- `in_ready` out 1: FIFO can accept; push occurs when `in_valid & in_ready`.
- `in_a`, `in_b` in `DATA_W`: operand pair.
- `A`, `B` out `DATA_W`: registered operands to the datapath.
- `load_a`, `load_b`, `load_m`, `load_acc`, `load_out`, `count_enable` out 1: datapath strobes.
- `busy` out 1: state ≠ IDLE.
- `seq_done` out 1: one-cycle pulse at end of run.
- `err` out 1: sticky; a `start` was dropped while busy.

## Operation
- **States:** IDLE, FETCH, MUL, MOV, ACC, OUT, DONE.
- **IDLE:**
  - `start` → FETCH.
  - The term counter clears to 0.
  - `err` clears on the accepting edge.
- **FETCH:**
  - FIFO non-empty → pop the head, register it into `A`/`B`, go to MUL.
  - FIFO empty → stay in FETCH. All strobes stay 0 and `A`/`B` hold.
- **MUL:** `load_a = load_b = 1` → MOV.
- **MOV:** `load_m = 1` → ACC.
- **ACC:**
  - `load_acc = count_enable = 1`.
  - If term counter = `N_TERMS-1` → OUT; otherwise increment the counter → FETCH.
- **OUT:** `load_out = 1` → DONE.
- **DONE:** `seq_done = 1` → IDLE.
- **Strobe rules:**
  - The five strobe groups are mutually exclusive and each lasts exactly one cycle. The datapath decodes them with priority, so overlap is forbidden.
  - `count_enable` produces exactly one rising edge per term.
- **FIFO:**
  - Accepts pushes in every state, including during a run.
  - `in_ready = !full`, forced 0 while `rst` is high.
  - Simultaneous push and pop when not full: both take effect and occupancy is unchanged.
  - No push when full.
  - A pop only happens in FETCH with the FIFO non-empty.
- **`start` while busy:** ignored by the FSM and sets `err`.
- **Reset (any cycle, including mid-run):**
  - State → IDLE; FIFO emptied; term counter → 0.
  - `A`, `B` = 0; all strobes = 0; `busy = seq_done = err = 0`.
  - A partial run is abandoned with no `seq_done`.
- **Widths:**
  - Term counter is 4 bits.
  - Worst-case datapath sum is 15·15·15 = 3375, which fits the datapath's 12-bit output; the sequencer does no arithmetic on data.

## Timing
- Reset values: all outputs 0. `in_ready` = 1 from the first cycle after `rst` deasserts.
- `start` sampled at edge k with ≥1 pair available per FETCH; term i (0-based) occupies:
  - FETCH: k+1+4i
  - MUL: k+2+4i
  - MOV: k+3+4i
  - ACC: k+4+4i
- Completion with default `N_TERMS` = 10:
  - OUT at k+41.
  - `seq_done` at k+42.
  - `busy` high in cycles k+1 through k+42.
  - Back in IDLE at k+43; a new `start` may be sampled at k+43.
- An empty FIFO adds one FETCH cycle per stalled cycle; all later term cycles shift by the same amount.
- All outputs are registered, except that `in_ready` is combinational from FIFO occupancy and `rst`.

## Structure
- Shared package `mac_pkg`:
  - State encoding constants (3-bit).
  - `MAC_DATA_W` = 4.
  - `MAC_N_TERMS` = 10.
  - Also used by `mac_datapath` benches.
- Sub-module `mac_operand_fifo`:
  - Synchronous FIFO, width 2·`DATA_W`, depth `FIFO_DEPTH`.
  - Pointers of log2(depth) bits; occupancy count of log2(depth)+1 bits.
  - Ports: push, pop, full, empty.
- Top level holds the FSM, term counter, `A`/`B` registers and `err`.

## Test plan
- **Full run:** push 4 pairs (a=1..4, b=2), `start` at cycle k, keep feeding a=5..10 → `seq_done` at k+42. Integrated `mac_datapath` `out` = 2·55 = 110 (0x06E). Exactly 10 `count_enable` pulses.
- **Stall:** empty FIFO, `start`, then feed one pair every 8 cycles → FSM waits in FETCH with all strobes 0. Each term's MUL follows its push by ≤2 cycles.
- **Full FIFO:** hold `in_valid=1` in IDLE with 5 distinct pairs → `in_ready` drops after the 4th push; the 5th pair stays pending and is accepted one cycle after the first pop.
- **Start while busy:** pulse `start` during term 3 → `err`=1, run timing unchanged. The next accepted `start` clears `err`.
- **Reset mid-run:** assert `rst` in the ACC of term 3 → next cycle all outputs 0, FIFO empty, no `seq_done`. A fresh run then completes normally.
- **Maximum operands:** all pairs a=b=15 → integrated `out` = 2250 (0x8CA). No strobe overlap in any cycle (assertion).

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: definitions shared by the MAC sequencer, its operand FIFO and
// the mac_datapath benches.
//   MAC_DATA_W     operand width of A/B
//   MAC_N_TERMS    products accumulated per run
//   MAC_FIFO_DEPTH operand FIFO entries (power of two)
//   MAC_TERM_W     term counter width (N_TERMS is legal in 1..15)
//   mac_state_t    3-bit sequencer state encoding
package mac_pkg;

  localparam int MAC_DATA_W     = 4;
  localparam int MAC_N_TERMS    = 10;
  localparam int MAC_FIFO_DEPTH = 4;
  localparam int MAC_TERM_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_MUL   = 3'd2,
    ST_MOV   = 3'd3,
    ST_ACC   = 3'd4,
    ST_OUT   = 3'd5,
    ST_DONE  = 3'd6
  } mac_state_t;

  // Counter value of the final term for a run of n_terms products.
  function automatic logic [MAC_TERM_W-1:0] last_term_idx(input int n_terms);
    return MAC_TERM_W'(n_terms - 1);
  endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if: operand-pair producer channel into the sequencer.
//   in_valid  producer holds an operand pair on in_a/in_b
//   in_ready  sequencer FIFO can take a pair this cycle
//   in_a/in_b operand pair, DATA_W bits each
// Handshake: a pair is transferred on every rising clock edge where
// in_valid && in_ready are both high. The producer keeps in_a/in_b stable
// while in_valid is high and ready is low; in_ready never depends on
// in_valid.
//   master modport: producer side
//   slave modport:  sequencer side
interface mac_sequencer_if
  import mac_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;

  modport master (output in_valid, output in_a, output in_b, input in_ready);
  modport slave  (input in_valid, input in_a, input in_b, output in_ready);

endinterface

// File: rtl/mac_operand_fifo.sv
// mac_operand_fifo: synchronous FIFO holding operand pairs.
//   clk, rst     clock, synchronous active-high reset (empties the FIFO)
//   push_i       write wdata_i (ignored when full)
//   pop_i        drop the head entry (ignored when empty)
//   wdata_i      entry to write
//   rdata_o      current head entry (valid while !empty_o)
//   full_o       DEPTH entries stored
//   empty_o      no entries stored
// Push and pop in the same cycle both take effect when the FIFO is not
// full (and not empty), leaving the occupancy unchanged.
module mac_operand_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Depth is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer: control and operand stage in front of mac_datapath.
// Operand pairs arrive through a small FIFO; on start the FSM presents
// N_TERMS pairs on A/B, pulsing load_a/load_b, load_m, load_acc with
// count_enable for each, then load_out and a one-cycle seq_done.
//   clk, rst        single clock, synchronous active-high reset
//   prod            producer channel (valid/ready operand pairs)
//   start           begin a run (acted on only in IDLE)
//   A, B            registered operands to the datapath
//   load_a, load_b, load_m, load_acc, load_out, count_enable
//                   registered datapath strobes, one cycle each
//   busy            state is not IDLE
//   seq_done        one-cycle end-of-run pulse
//   err             sticky: a start arrived while busy
//   dbg_state_o     current FSM state
// All outputs are registered except prod.in_ready, which is combinational
// from FIFO occupancy and rst.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int DATA_W     = MAC_DATA_W,
  parameter int N_TERMS    = MAC_N_TERMS,
  parameter int FIFO_DEPTH = MAC_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  mac_sequencer_if.slave    prod,
  input  logic              start,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              load_a,
  output logic              load_b,
  output logic              load_m,
  output logic              load_acc,
  output logic              load_out,
  output logic              count_enable,
  output logic              busy,
  output logic              seq_done,
  output logic              err,
  output mac_state_t        dbg_state_o
);

  localparam logic [MAC_TERM_W-1:0] LAST_TERM = last_term_idx(N_TERMS);

  mac_state_t            state_q;
  logic [MAC_TERM_W-1:0] term_q;
  logic [DATA_W-1:0]     a_q, b_q;
  logic                  load_ab_q, load_m_q, load_acc_q, load_out_q;
  logic                  seq_done_q, busy_q, err_q;

  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [2*DATA_W-1:0]   fifo_head;

  // ---------------------------------------------------------------------
  // Operand FIFO: accepts pushes in every state, pops only in FETCH.
  // ---------------------------------------------------------------------
  assign prod.in_ready = !fifo_full && !rst;
  assign fifo_push     = prod.in_valid && prod.in_ready;
  assign fifo_pop      = (state_q == ST_FETCH) && !fifo_empty;

  mac_operand_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({prod.in_a, prod.in_b}),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------------------------------------------------------------
  // FSM. Each strobe register is set on the transition into the state it
  // belongs to, so it is high for exactly the cycle spent in that state
  // and no two strobe groups can ever overlap.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      term_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      load_ab_q  <= 1'b0;
      load_m_q   <= 1'b0;
      load_acc_q <= 1'b0;
      load_out_q <= 1'b0;
      seq_done_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      load_ab_q  <= 1'b0;
      load_m_q   <= 1'b0;
      load_acc_q <= 1'b0;
      load_out_q <= 1'b0;
      seq_done_q <= 1'b0;

      // err clears when a start is accepted, and latches on a start that
      // the FSM has to drop because a run is in progress.
      if (state_q == ST_IDLE) begin
        if (start) err_q <= 1'b0;
      end else if (start) begin
        err_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          term_q <= '0;
          if (start) begin
            state_q <= ST_FETCH;
            busy_q  <= 1'b1;
          end
        end
        ST_FETCH: begin
          // Empty FIFO: wait here with strobes low and A/B held.
          if (!fifo_empty) begin
            a_q       <= fifo_head[2*DATA_W-1:DATA_W];
            b_q       <= fifo_head[DATA_W-1:0];
            load_ab_q <= 1'b1;
            state_q   <= ST_MUL;
          end
        end
        ST_MUL: begin
          load_m_q <= 1'b1;
          state_q  <= ST_MOV;
        end
        ST_MOV: begin
          load_acc_q <= 1'b1;
          state_q    <= ST_ACC;
        end
        ST_ACC: begin
          if (term_q == LAST_TERM) begin
            load_out_q <= 1'b1;
            state_q    <= ST_OUT;
          end else begin
            term_q  <= term_q + 4'd1;
            state_q <= ST_FETCH;
          end
        end
        ST_OUT: begin
          seq_done_q <= 1'b1;
          state_q    <= ST_DONE;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign A            = a_q;
  assign B            = b_q;
  assign load_a       = load_ab_q;
  assign load_b       = load_ab_q;
  assign load_m       = load_m_q;
  assign load_acc     = load_acc_q;
  assign count_enable = load_acc_q;
  assign load_out     = load_out_q;
  assign busy         = busy_q;
  assign seq_done     = seq_done_q;
  assign err          = err_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: directed bench for mac_sequencer with a small
// behavioural mac_datapath model (out = sum of A*B per run).
module tb_mac_sequencer;
  import mac_pkg::*;

  localparam int DW = 4;
  localparam int NT = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] A, B;
  logic          load_a, load_b, load_m, load_acc, load_out, count_enable;
  logic          busy, seq_done, err;
  mac_state_t    dbg_state;

  mac_sequencer_if #(.DATA_W(DW)) prod_if ();

  mac_sequencer #(.DATA_W(DW), .N_TERMS(NT), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .prod         (prod_if),
    .start        (start),
    .A            (A),
    .B            (B),
    .load_a       (load_a),
    .load_b       (load_b),
    .load_m       (load_m),
    .load_acc     (load_acc),
    .load_out     (load_out),
    .count_enable (count_enable),
    .busy         (busy),
    .seq_done     (seq_done),
    .err          (err),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [2*DW-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Datapath model and run statistics, sampled on the falling edge.
  logic [DW-1:0] ra = '0, rb = '0, prev_a = '0, prev_b = '0;
  int  m_val = 0, acc_val = 0, out_val = 0;
  int  ce_cnt = 0, busy_cnt = 0, done_cnt = 0, done_edge = 0;
  int  last_push_edge = 0;
  bit  stall_mode = 0;
  logic prev_ce = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin : monitor
    int groups;
    if (rst === 1'b0) begin
      groups = int'(load_a | load_b) + int'(load_m) + int'(load_acc | count_enable)
             + int'(load_out) + int'(seq_done);
      check("strobe_overlap", int'(groups > 1), 0);
      check("strobe_pairs", {30'd0, load_a ^ load_b, load_acc ^ count_enable}, 0);
      if (dbg_state == ST_FETCH)
        check("fetch_hold", int'(({A, B} != {prev_a, prev_b}) || (groups != 0)), 0);
      if (busy && !prev_busy) acc_val = 0;
      if (load_a) begin
        if (exp_q.size() == 0) check("sb_underflow", 1, 0);
        else check("operand_order", int'({A, B}), int'(exp_q.pop_front()));
        ra = A;
        rb = B;
        if (stall_mode) check("stall_mul_latency", int'((cyc - last_push_edge) <= 2), 1);
      end
      if (load_m)   m_val = int'(ra) * int'(rb);
      if (load_acc) acc_val = acc_val + m_val;
      if (load_out) out_val = acc_val & 12'hfff;
      if (count_enable && !prev_ce) ce_cnt++;
      if (busy) busy_cnt++;
      if (seq_done) begin
        done_cnt++;
        done_edge = cyc;
      end
    end
    prev_ce   = count_enable;
    prev_busy = busy;
    prev_a    = A;
    prev_b    = B;
  end

  // ---------------- driver tasks ----------------
  task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int guard = 0;
    @(negedge clk);
    prod_if.in_valid = 1'b1;
    prod_if.in_a     = a;
    prod_if.in_b     = b;
    #1;
    while (!prod_if.in_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!prod_if.in_ready) begin
      check("push_timeout", 0, 1);
      prod_if.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    prod_if.in_valid = 1'b0;
    last_push_edge = cyc;
    exp_q.push_back({a, b});
  endtask

  task automatic feed(input int first, input int last, input int a0, input int as,
                      input int b0, input int bs, input int gap);
    for (int i = first; i <= last; i++) begin
      repeat (gap) @(negedge clk);
      push_pair(DW'(a0 + as * i), DW'(b0 + bs * i));
    end
  endtask

  // Accepted start: edge number k is returned; err must clear on that edge.
  task automatic start_run(output int k);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    k        = cyc;
    ce_cnt   = 0;
    busy_cnt = 0;
    check("err_clear_on_start", int'(err), 0);
  endtask

  task automatic wait_done(input int prev_cnt);
    int guard = 0;
    while (done_cnt == prev_cnt && guard < 400) begin
      @(posedge clk);
      guard++;
    end
    check("done_seen", int'(done_cnt > prev_cnt), 1);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, int'({A, B, load_a, load_b, load_m, load_acc, load_out,
                      count_enable, busy, seq_done, err}), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int a0, as, b0, bs;  // a_i = a0 + as*i, b_i = b0 + bs*i
    int exp_out;         // hand-computed sum of a_i*b_i, i = 0..9
  } vec_t;
  vec_t vecs[5];

  task automatic run_vec(input vec_t v, input string tag);
    int k, d0;
    feed(0, 3, v.a0, v.as, v.b0, v.bs, 0);
    d0 = done_cnt;
    fork
      feed(4, NT - 1, v.a0, v.as, v.b0, v.bs, 0);
      start_run(k);
    join
    wait_done(d0);
    check({tag, "_done_latency"}, done_edge + 1 - k, 42);
    check({tag, "_out"}, out_val, v.exp_out);
    check({tag, "_ce_pulses"}, ce_cnt, NT);
    check({tag, "_busy_cycles"}, busy_cnt, 42);
    check({tag, "_sb_drained"}, exp_q.size(), 0);
    @(negedge clk);
    #1;
    check({tag, "_idle_after"}, int'({busy, dbg_state}), int'({1'b0, ST_IDLE}));
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int k, d0, p5;
    vecs[0] = '{a0: 1,  as: 1, b0: 2,  bs: 0, exp_out: 110};
    vecs[1] = '{a0: 15, as: 0, b0: 15, bs: 0, exp_out: 2250};
    vecs[2] = '{a0: 1,  as: 1, b0: 1,  bs: 1, exp_out: 385};
    vecs[3] = '{a0: 3,  as: 0, b0: 5,  bs: 0, exp_out: 150};
    vecs[4] = '{a0: 0,  as: 1, b0: 15, bs: 0, exp_out: 675};

    rst = 1'b1;
    start = 1'b0;
    prod_if.in_valid = 1'b0;
    prod_if.in_a = '0;
    prod_if.in_b = '0;
    repeat (3) @(negedge clk);
    #1;
    check("ready_low_in_reset", int'(prod_if.in_ready), 0);
    check_outputs_zero("outputs_in_reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_reset", int'(prod_if.in_ready), 1);
    check_outputs_zero("outputs_after_reset");
    check("state_after_reset", int'(dbg_state), int'(ST_IDLE));

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Stall: empty FIFO, one pair every 8 cycles; out = 3*55.
    d0 = done_cnt;
    fork
      start_run(k);
      begin
        repeat (3) @(negedge clk);
        stall_mode = 1;
        feed(0, NT - 1, 1, 1, 3, 0, 8);
      end
    join
    wait_done(d0);
    stall_mode = 0;
    check("stall_out", out_val, 165);
    check("stall_ce_pulses", ce_cnt, NT);
    check("stall_extends_run", int'((done_edge + 1 - k) > 42), 1);

    // Full FIFO: 5th pair waits, accepted the edge after the first pop.
    feed(0, 3, 1, 1, 1, 0, 0);
    @(negedge clk);
    prod_if.in_valid = 1'b1;
    prod_if.in_a = 4'd5;
    prod_if.in_b = 4'd1;
    #1;
    check("ready_low_when_full", int'(prod_if.in_ready), 0);
    d0 = done_cnt;
    fork
      begin
        push_pair(4'd5, 4'd1);
        p5 = last_push_edge;
        feed(5, NT - 1, 1, 1, 1, 0, 0);
      end
      start_run(k);
    join
    check("fifth_accept_edge", p5 - k, 2);
    wait_done(d0);
    check("full_out", out_val, 55);

    // Start while busy: err set, timing unchanged.
    feed(0, 3, 1, 1, 2, 0, 0);
    d0 = done_cnt;
    fork
      feed(4, NT - 1, 1, 1, 2, 0, 0);
      begin
        start_run(k);
        while (cyc < k + 12) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        #1;
        check("err_set_on_busy_start", int'(err), 1);
      end
    join
    wait_done(d0);
    check("busy_start_latency", done_edge + 1 - k, 42);
    check("busy_start_out", out_val, 110);
    check("busy_start_ce", ce_cnt, NT);
    check("err_sticky", int'(err), 1);
    run_vec(vecs[3], "after_err");

    // Reset in the ACC of term 3 with a spare pair still queued.
    feed(0, 3, 2, 0, 4, 1, 0);
    start_run(k);
    push_pair(4'd2, 4'd8);
    while (cyc < k + 15) @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_hit_acc", int'(dbg_state), int'(ST_ACC));
    check("ready_forced_low", int'(prod_if.in_ready), 0);
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check_outputs_zero("outputs_after_midrun_reset");
    check("state_after_midrun_reset", int'(dbg_state), int'(ST_IDLE));
    check("ready_after_midrun_reset", int'(prod_if.in_ready), 1);
    repeat (50) @(negedge clk);
    check("no_done_after_reset", done_cnt, d0);
    run_vec(vecs[1], "fresh_run");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #300000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
